// File: rtl/result_monitor_if.sv
// Data-memory write snoop bus plus expected-table load port for result_monitor.
interface result_monitor_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              wen;
  logic              stall;
  logic              ld_en;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_data;
  logic [IDX_W:0]    exp_len;

  modport master (output addr, data, wen, stall, ld_en, ld_idx, ld_data, exp_len);
  modport slave  (input  addr, data, wen, stall, ld_en, ld_idx, ld_data, exp_len);
endinterface

// File: rtl/result_monitor.sv
// Self-checking result monitor: snoops test-port writes and compares them to a loadable table.
// Optional watchdog enabled by defining MON_TIMEOUT_EN.
module result_monitor #(
  parameter int                ADDR_W    = 30,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 64,
  parameter logic [ADDR_W-1:0] TEST_PORT = 'h40,
  parameter logic [DATA_W-1:0] BEGIN_SYM = 'h932,
  parameter logic [15:0]       TIMEOUT   = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  result_monitor_if.slave           bus,
  output logic [7:0]                error_num,
  output logic [15:0]               duration,
  output logic                      finish,
  output logic                      pass,
  output logic                      timeout,
  output logic [$clog2(DEPTH)-1:0]  first_err_idx,
  output logic [DATA_W-1:0]         first_err_data
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

  state_t            state, state_nx;
  logic              blk;
  logic              accept;
  logic              hit;
  logic [IDX_W:0]    idx;
  logic [IDX_W:0]    len;
  logic [DATA_W-1:0] exp_tbl [DEPTH];
  logic              cmp_vld;
  logic              cmp_miss;
  logic [IDX_W-1:0]  cmp_idx;
  logic [DATA_W-1:0] cmp_data;

  // blk suppresses re-acceptance while wen is held across a cache stall
  assign accept = bus.wen & ~bus.stall & ~blk;
  assign hit    = accept & (bus.addr == TEST_PORT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          blk <= 1'b0;
    else if (!bus.wen) blk <= 1'b0;
    else if (accept)   blk <= 1'b1;
  end

  // Expected table has no reset so it survives a mid-run reset
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.ld_en) exp_tbl[bus.ld_idx] <= bus.ld_data;
  end

`ifdef MON_TIMEOUT_EN
  logic to_hit;
`endif

  always_comb begin
    state_nx = state;
`ifdef MON_TIMEOUT_EN
    to_hit   = 1'b0;
`endif
    case (state)
      IDLE:   if (hit && bus.data == BEGIN_SYM) state_nx = CHECK;
      CHECK: begin
`ifdef MON_TIMEOUT_EN
        if (duration == TIMEOUT - 16'd1) begin
          to_hit   = 1'b1;
          state_nx = REPORT;
        end
`endif
        if (idx == len) state_nx = REPORT;
      end
      REPORT: state_nx = REPORT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx            <= '0;
      len            <= '0;
      error_num      <= '1;
      duration       <= '0;
      finish         <= 1'b0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      cmp_vld        <= 1'b0;
      cmp_miss       <= 1'b0;
      cmp_idx        <= '0;
      cmp_data       <= '0;
    end else begin
      cmp_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (state_nx == CHECK) begin
            len            <= bus.exp_len;
            idx            <= '0;
            error_num      <= '0;
            duration       <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
          end
        end
        CHECK: begin
          if (duration != '1) duration <= duration + 16'd1;
          if (hit && idx != len) begin
            cmp_vld  <= 1'b1;
            cmp_miss <= (bus.data != exp_tbl[idx[IDX_W-1:0]]);
            cmp_idx  <= idx[IDX_W-1:0];
            cmp_data <= bus.data;
            idx      <= idx + 1'b1;
          end
          // Compare result lands one cycle after acceptance, still inside CHECK
          if (cmp_vld && cmp_miss) begin
            if (error_num != '1) error_num <= error_num + 8'd1;
            if (error_num == '0) begin
              first_err_idx  <= cmp_idx;
              first_err_data <= cmp_data;
            end
          end
          if (state_nx == REPORT) finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MON_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            timeout <= 1'b0;
    else if (state == CHECK && to_hit)   timeout <= 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  assign pass = finish & (error_num == 8'd0) & ~timeout;

endmodule

// File: tb/tb_result_monitor.sv
// Directed bench for result_monitor: Fibonacci up/down table, stalls, noise writes, resets.
module tb_result_monitor;
  localparam logic [29:0] TP  = 30'h40;
  localparam logic [31:0] BEG = 32'h932;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  error_num;
  logic [15:0] duration;
  logic        finish, pass, timeout;
  logic [5:0]  first_err_idx;
  logic [31:0] first_err_data;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] fib [33] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610,
                            610, 377, 233, 144, 89, 55, 34, 21, 13, 8, 5, 3, 2, 1, 1, 0,
                            32'hD5D};

  result_monitor_if #(.ADDR_W(30), .DATA_W(32), .IDX_W(6)) bus ();

  result_monitor #(
    .ADDR_W(30), .DATA_W(32), .DEPTH(64),
    .TEST_PORT(30'h40), .BEGIN_SYM(32'h932), .TIMEOUT(16'd100)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .error_num(error_num), .duration(duration), .finish(finish), .pass(pass),
    .timeout(timeout), .first_err_idx(first_err_idx), .first_err_data(first_err_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // wen held for ns stalled cycles plus one accepting cycle, then dropped for one cycle
  task automatic wr(input logic [29:0] a, input logic [31:0] d, input int ns);
    bus.addr  = a;
    bus.data  = d;
    bus.wen   = 1'b1;
    bus.stall = (ns > 0);
    repeat (ns) tick();
    bus.stall = 1'b0;
    tick();
    bus.wen = 1'b0;
    tick();
  endtask

  task automatic do_run(input int len, input int nw, input int ns, input bit noise, input bit corrupt);
    logic [31:0] d;
    bus.exp_len = 7'(len);
    wr(TP, BEG, ns);
    for (int k = 0; k < nw; k++) begin
      if (noise) wr(30'h41, $urandom, 0);
      d = fib[k];
      if (corrupt && (k == 5 || k == 20)) d = d + 1;
      wr(TP, d, ns);
    end
  endtask

  task automatic wait_finish(input int budget);
    for (int i = 0; i < budget && finish !== 1'b1; i++) tick();
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    bus.addr = '0; bus.data = '0; bus.wen = 1'b0; bus.stall = 1'b0;
    bus.ld_en = 1'b0; bus.ld_idx = '0; bus.ld_data = '0; bus.exp_len = '0;
    tick(); tick();
    check("rst_error_num", 32'(error_num), 32'hFF);
    check("rst_duration", 32'(duration), 0);
    check("rst_finish", 32'(finish), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_first_idx", 32'(first_err_idx), 0);
    check("rst_first_data", first_err_data, 0);
    rst = 1'b1;
    tick();

    for (int k = 0; k < 33; k++) begin
      bus.ld_en = 1'b1; bus.ld_idx = 6'(k); bus.ld_data = fib[k];
      tick();
    end
    bus.ld_en = 1'b0;

    // clean run
    do_run(33, 33, 0, 1'b0, 1'b0);
    wait_finish(10);
    check("clean_finish", 32'(finish), 1);
    check("clean_error_num", 32'(error_num), 0);
    check("clean_pass", 32'(pass), 1);
    check("clean_duration", 32'(duration), 67);
    check("clean_timeout", 32'(timeout), 0);
    // REPORT ignores loads and writes
    bus.ld_en = 1'b1; bus.ld_idx = 6'd0; bus.ld_data = 32'hBAD;
    tick();
    bus.ld_en = 1'b0;
    wr(TP, BEG, 0);
    wr(TP, 32'h1234, 0);
    check("report_frozen_err", 32'(error_num), 0);
    check("report_frozen_dur", 32'(duration), 67);

    reset_pulse();
    do_run(33, 33, 0, 1'b0, 1'b1);
    wait_finish(10);
    check("corrupt_finish", 32'(finish), 1);
    check("corrupt_error_num", 32'(error_num), 2);
    check("corrupt_first_idx", 32'(first_err_idx), 5);
    check("corrupt_first_data", first_err_data, 6);
    check("corrupt_pass", 32'(pass), 0);

    reset_pulse();
    do_run(33, 33, 3, 1'b0, 1'b0);
    wait_finish(10);
    check("stall_finish", 32'(finish), 1);
    check("stall_error_num", 32'(error_num), 0);
    check("stall_duration", 32'(duration), 166);
    check("stall_pass", 32'(pass), 1);

    reset_pulse();
    do_run(33, 33, 0, 1'b1, 1'b0);
    wait_finish(10);
    check("noise_finish", 32'(finish), 1);
    check("noise_error_num", 32'(error_num), 0);
    check("noise_first_data", first_err_data, 0);
    check("noise_pass", 32'(pass), 1);

    // begin symbol inside CHECK is an ordinary value (mismatches table[0]=0)
    reset_pulse();
    bus.exp_len = 7'd2;
    wr(TP, BEG, 0);
    wr(TP, BEG, 0);
    wr(TP, 32'd1, 0);
    wait_finish(10);
    check("beginsym_error_num", 32'(error_num), 1);
    check("beginsym_first_idx", 32'(first_err_idx), 0);
    check("beginsym_first_data", first_err_data, 32'h932);

    reset_pulse();
    bus.exp_len = 7'd0;
    wr(TP, BEG, 0);
    check("len0_finish", 32'(finish), 1);
    check("len0_duration", 32'(duration), 1);
    check("len0_pass", 32'(pass), 1);

    // asynchronous reset mid-run at idx=10, then rerun on the retained table
    reset_pulse();
    do_run(33, 10, 0, 1'b0, 1'b0);
    check("mid_finish_pre", 32'(finish), 0);
    check("mid_error_pre", 32'(error_num), 0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_error_num", 32'(error_num), 32'hFF);
    check("mid_rst_finish", 32'(finish), 0);
    check("mid_rst_duration", 32'(duration), 0);
    tick();
    rst = 1'b1;
    tick();
    do_run(33, 33, 0, 1'b0, 1'b0);
    wait_finish(10);
    check("rerun_finish", 32'(finish), 1);
    check("rerun_pass", 32'(pass), 1);

    reset_pulse();
    do_run(33, 3, 0, 1'b0, 1'b0);
    wait_finish(200);
`ifdef MON_TIMEOUT_EN
    check("wd_finish", 32'(finish), 1);
    check("wd_timeout", 32'(timeout), 1);
    check("wd_pass", 32'(pass), 0);
    check("wd_duration", 32'(duration), 100);
`else
    check("nowd_finish", 32'(finish), 0);
    check("nowd_timeout", 32'(timeout), 0);
    check("nowd_pass", 32'(pass), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
